// File: rtl/char_plot_pkg.sv
// Shared constants, state encoding and glyph bit addressing for the character plotter.
package char_plot_pkg;

  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 16;
  localparam int GLYPH_BITS = 128;

  localparam logic [6:0] CODE_FIRST_PRINT = 7'h20;
  localparam logic [6:0] CODE_DEL         = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_DONE
  } plot_state_t;

  // Row 0 sits in the top byte, MSB of each byte is the leftmost column.
  function automatic logic [6:0] glyph_bit_idx(input logic [3:0] r, input logic [2:0] c);
    return 7'(GLYPH_BITS - 1 - GLYPH_W * int'(r) - int'(c));
  endfunction

endpackage

// File: rtl/char_plotter.sv
// Character plotter: fetches one 8x16 glyph and emits an (x,y) pixel request per lit dot.
// Optional integer scaling (1x..4x) via the char_size port when CHAR_PLOT_SCALE_EN is defined.
module char_plotter
  import char_plot_pkg::*;
#(
  parameter int X_W = 11,
  parameter int Y_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  char_valid,
  output logic                  char_ready,
  input  logic [6:0]            char_code,
  input  logic [X_W-1:0]        org_x,
  input  logic [Y_W-1:0]        org_y,
`ifdef CHAR_PLOT_SCALE_EN
  input  logic [1:0]            char_size,
`endif
  output logic [6:0]            rom_addr,
  input  logic [GLYPH_BITS-1:0] rom_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [X_W-1:0]        pix_x,
  output logic [Y_W-1:0]        pix_y,
  output logic                  busy,
  output logic                  done
);

  plot_state_t           r_state;
  logic [6:0]            r_rom_addr;
  logic [6:0]            r_cell;
  logic [GLYPH_BITS-1:0] r_glyph;
  logic [X_W-1:0]        r_org_x;
  logic [Y_W-1:0]        r_org_y;
  logic [X_W-1:0]        r_pix_x;
  logic [Y_W-1:0]        r_pix_y;
  logic                  r_pix_valid;
  logic                  r_done;
  logic                  r_char_ready;
  logic                  r_busy;

  logic [3:0]     w_row;
  logic [2:0]     w_col;
  logic           w_lit;
  logic           w_last_cell;
  logic           w_printable;
  logic           w_sub_last;
  logic           w_advance;
  logic [X_W-1:0] w_cell_x;
  logic [Y_W-1:0] w_cell_y;
  logic [X_W-1:0] w_next_x;
  logic [Y_W-1:0] w_next_y;

  // The cell counter is row-major: upper bits select the row, lower bits the column.
  assign w_row       = r_cell[6:3];
  assign w_col       = r_cell[2:0];
  assign w_lit       = r_glyph[glyph_bit_idx(w_row, w_col)];
  assign w_last_cell = (r_cell == 7'(GLYPH_BITS - 1));
  assign w_printable = (r_rom_addr >= CODE_FIRST_PRINT) && (r_rom_addr != CODE_DEL);

`ifdef CHAR_PLOT_SCALE_EN
  logic [1:0] r_scale;
  logic [1:0] r_sx;
  logic [1:0] r_sy;
  logic [1:0] w_sx_next;
  logic [1:0] w_sy_next;
  logic [2:0] w_s;
  logic [4:0] w_col_off;
  logic [5:0] w_row_off;

  assign w_s        = {1'b0, r_scale} + 3'd1;
  assign w_col_off  = {2'b00, w_col} * {2'b00, w_s};
  assign w_row_off  = {2'b00, w_row} * {3'b000, w_s};
  assign w_cell_x   = r_org_x + X_W'(w_col_off);
  assign w_cell_y   = r_org_y + Y_W'(w_row_off);
  // Sub-pixels walk sx fastest, then sy, covering an s x s block per dot.
  assign w_sub_last = (r_sx == r_scale) && (r_sy == r_scale);
  assign w_sx_next  = (r_sx == r_scale) ? 2'd0 : r_sx + 2'd1;
  assign w_sy_next  = (r_sx == r_scale) ? r_sy + 2'd1 : r_sy;
  assign w_next_x   = w_cell_x + X_W'(w_sx_next);
  assign w_next_y   = w_cell_y + Y_W'(w_sy_next);
`else
  assign w_cell_x   = r_org_x + X_W'(w_col);
  assign w_cell_y   = r_org_y + Y_W'(w_row);
  assign w_sub_last = 1'b1;
  assign w_next_x   = w_cell_x;
  assign w_next_y   = w_cell_y;
`endif

  // A cell is finished when it is unlit, or when its last sub-pixel is handed off.
  assign w_advance = (r_state == ST_SCAN) &&
                     (r_pix_valid ? (pix_ready && w_sub_last) : !w_lit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rom_addr   <= '0;
      r_cell       <= '0;
      r_glyph      <= '0;
      r_org_x      <= '0;
      r_org_y      <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_char_ready <= 1'b1;
      r_busy       <= 1'b0;
`ifdef CHAR_PLOT_SCALE_EN
      r_scale      <= '0;
      r_sx         <= '0;
      r_sy         <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (char_valid) begin
            r_rom_addr   <= char_code;
            r_org_x      <= org_x;
            r_org_y      <= org_y;
`ifdef CHAR_PLOT_SCALE_EN
            r_scale      <= char_size;
`endif
            r_char_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_glyph <= rom_data;
          r_cell  <= '0;
          if (w_printable) begin
            r_state <= ST_SCAN;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_SCAN: begin
          if (w_advance) begin
            r_pix_valid <= 1'b0;
            if (w_last_cell) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cell <= r_cell + 7'd1;
            end
          end else if (r_pix_valid) begin
            // Stalled pixels hold; an accepted non-final sub-pixel steps to the next one.
            if (pix_ready) begin
              r_pix_x <= w_next_x;
              r_pix_y <= w_next_y;
`ifdef CHAR_PLOT_SCALE_EN
              r_sx    <= w_sx_next;
              r_sy    <= w_sy_next;
`endif
            end
          end else begin
            r_pix_valid <= 1'b1;
            r_pix_x     <= w_cell_x;
            r_pix_y     <= w_cell_y;
`ifdef CHAR_PLOT_SCALE_EN
            r_sx        <= 2'd0;
            r_sy        <= 2'd0;
`endif
          end
        end
        ST_DONE: begin
          r_busy       <= 1'b0;
          r_char_ready <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign char_ready = r_char_ready;
  assign rom_addr   = r_rom_addr;
  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_char_plotter.sv
// Directed bench for char_plotter: glyph ROM model, pixel scoreboard queue, latency and reset checks.
`timescale 1ns/1ps
module tb_char_plotter;

  localparam int X_W = 11;
  localparam int Y_W = 11;
  localparam int PW  = X_W + Y_W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           char_valid = 1'b0;
  logic           char_ready;
  logic [6:0]     char_code = '0;
  logic [X_W-1:0] org_x = '0;
  logic [Y_W-1:0] org_y = '0;
  logic [1:0]     char_size = '0;
  logic [6:0]     rom_addr;
  logic [127:0]   rom_data;
  logic           pix_valid;
  logic           pix_ready = 1'b0;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           busy;
  logic           done;
  logic           rom_garble = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] log_q[$];

  always #5 clk = ~clk;

  function automatic logic [127:0] tb_glyph(input logic [6:0] code);
    logic [127:0] g;
    case (code)
      7'h2E:   g = {80'h0, 8'h10, 8'h10, 32'h0};
      7'h2D:   g = {56'h0, 8'h7E, 64'h0};
      7'h38:   g = {16'h0, 64'h3C66_423C_6642_423C, 48'h0};
      7'h20:   g = '0;
      default: g = '1;
    endcase
    return g;
  endfunction

  // Outside the load cycle the ROM output is scrambled; the plotter must not care.
  assign rom_data = tb_glyph(rom_addr) ^ {128{rom_garble}};

  char_plotter #(.X_W(X_W), .Y_W(Y_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .char_code (char_code),
    .org_x     (org_x),
    .org_y     (org_y),
`ifdef CHAR_PLOT_SCALE_EN
    .char_size (char_size),
`endif
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_char(input logic [6:0] code, input logic [X_W-1:0] ox,
                          input logic [Y_W-1:0] oy, input logic [1:0] sz,
                          input bit rnd, input string tag);
    logic [127:0]   g;
    logic [X_W-1:0] ex;
    logic [Y_W-1:0] ey;
    logic [PW-1:0]  held;
    logic [PW-1:0]  got;
    logic [PW-1:0]  want;
    int s, ndots, lat, done_k, n_exp;
    bit stalled;
    g = tb_glyph(code);
    s = 1;
`ifdef CHAR_PLOT_SCALE_EN
    s = int'(sz) + 1;
`endif
    ndots = 0;
    exp_q.delete();
    log_q.delete();
    if (code >= 7'h20 && code != 7'h7F) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 8; c++)
          if (g[127 - 8*r - c]) begin
            ndots++;
            for (int sy = 0; sy < s; sy++)
              for (int sx = 0; sx < s; sx++) begin
                ex = ox + X_W'(c*s + sx);
                ey = oy + Y_W'(r*s + sy);
                exp_q.push_back({ex, ey});
              end
          end
      lat = 130 + ndots * s * s;
    end else begin
      lat = 2;
    end
    n_exp = exp_q.size();

    @(negedge clk);
    chk({tag, "_ready_idle"}, 128'(char_ready), 128'(1));
    char_valid = 1'b1;
    char_code  = code;
    org_x      = ox;
    org_y      = oy;
    char_size  = sz;
    rom_garble = 1'b1;
    pix_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    char_code  = 7'h2E;
    org_x      = ~ox;
    org_y      = ~oy;
    rom_garble = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    chk({tag, "_ready_busy"}, 128'(char_ready), 128'(0));

    done_k  = -1;
    stalled = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      if (k == 2) rom_garble = 1'b1;
      if (stalled) chk({tag, "_stall_hold"}, 128'({pix_valid, pix_x, pix_y}), 128'({1'b1, held}));
      if (done) begin
        done_k = k;
        break;
      end
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled   = 1'b0;
      if (pix_valid) begin
        if (pix_ready) begin
          got = {pix_x, pix_y};
          log_q.push_back(got);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk({tag, "_pixel"}, 128'(got), 128'(want));
          end
        end else begin
          stalled = 1'b1;
          held    = {pix_x, pix_y};
        end
      end
      @(negedge clk);
    end
    rom_garble = 1'b0;
    chk({tag, "_done_seen"}, 128'(done_k >= 0), 128'(1));
    if (!rnd) chk({tag, "_latency"}, 128'(done_k), 128'(lat));
    chk({tag, "_pix_count"}, 128'(log_q.size()), 128'(n_exp));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 128'(done), 128'(0));
    chk({tag, "_ready_back"}, 128'(char_ready), 128'(1));
    chk({tag, "_idle_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int nd, nv;
    bit seen;
    logic [X_W-1:0] xv;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(char_ready), 128'(1));
    chk("rst_pix_valid", 128'(pix_valid), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_pix_xy", 128'({pix_x, pix_y}), 128'(0));
    chk("rst_rom_addr", 128'(rom_addr), 128'(0));
    rst = 1'b0;

    run_char(7'h2E, 11'd100, 11'd200, 2'd0, 1'b0, "dot");
    chk("dot_p0", 128'(log_q[0]), 128'({11'd103, 11'd210}));
    chk("dot_p1", 128'(log_q[1]), 128'({11'd103, 11'd211}));

    run_char(7'h20, 11'd5, 11'd5, 2'd0, 1'b0, "space");
    run_char(7'h07, 11'd0, 11'd0, 2'd0, 1'b0, "bel");
    run_char(7'h7F, 11'd0, 11'd0, 2'd0, 1'b0, "del");

    run_char(7'h38, 11'd300, 11'd40, 2'd0, 1'b1, "eight");
    chk("eight_total", 128'(log_q.size()), 128'(26));

    run_char(7'h2D, 11'd2044, 11'd0, 2'd0, 1'b0, "dash");
    for (int i = 0; i < 6; i++) begin
      xv = 11'(2045 + i);
      chk("dash_wrap", 128'(log_q[i]), 128'({xv, 11'd7}));
    end

`ifdef CHAR_PLOT_SCALE_EN
    run_char(7'h2E, 11'd0, 11'd0, 2'd1, 1'b0, "dot2x");
    chk("dot2x_total", 128'(log_q.size()), 128'(8));
    for (int i = 0; i < 8; i++)
      chk("dot2x_px", 128'(log_q[i]), 128'({11'(6 + i % 2), 11'(20 + i / 2)}));
    run_char(7'h38, 11'd100, 11'd100, 2'd3, 1'b1, "eight4x");
`endif

    // Abort in the middle of a stalled pixel.
    pix_ready = 1'b0;
    @(negedge clk);
    char_valid = 1'b1;
    char_code  = 7'h38;
    org_x      = 11'd10;
    org_y      = 11'd10;
    char_size  = 2'd0;
    @(negedge clk);
    char_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (pix_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_pix_seen", 128'(seen), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pix_valid", 128'(pix_valid), 128'(0));
    chk("abort_ready", 128'(char_ready), 128'(1));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_pix_xy", 128'({pix_x, pix_y}), 128'(0));
    chk("abort_rom_addr", 128'(rom_addr), 128'(0));
    rst = 1'b0;
    pix_ready = 1'b1;
    nd = 0;
    nv = 0;
    repeat (150) begin
      @(negedge clk);
      nd += int'(done);
      nv += int'(pix_valid);
    end
    chk("abort_no_done", 128'(nd), 128'(0));
    chk("abort_no_pix", 128'(nv), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
